// File: rtl/prog_mem_responder_if.sv
// Bus bundle between the CPU/host side (master) and the program-memory responder (slave).
// Carries the CPU strobes, the loader stream, the check stream and the load/check status.
interface prog_mem_responder_if #(
   parameter int ADDR_W = 8
);
   logic [1:0]        cpustate;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic [7:0]        rdata;
   logic              ld_valid;
   logic [7:0]        ld_data;
   logic              ld_ready;
   logic              chk_valid;
   logic [7:0]        chk_data;
   logic              chk_ready;
   logic [ADDR_W:0]   ld_count;
   logic              ld_full;
   logic              chk_done;

   modport master (
      output cpustate, read, write, addr, wdata, ld_valid, ld_data, chk_ready,
      input  rdata, ld_ready, chk_valid, chk_data, ld_count, ld_full, chk_done
   );

   modport slave (
      input  cpustate, read, write, addr, wdata, ld_valid, ld_data, chk_ready,
      output rdata, ld_ready, chk_valid, chk_data, ld_count, ld_full, chk_done
   );
endinterface

// File: rtl/prog_mem_responder.sv
// Program/data RAM responder: serves CPU read/write strobes in RUN, accepts a loader
// byte stream in IN and streams the loaded bytes back to the host in CHECK.
module prog_mem_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   prog_mem_responder_if.slave    bus
);
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_LOAD  = 2'b01;
   localparam logic [1:0] S_CHECK = 2'b10;
   localparam logic [1:0] S_RUN   = 2'b11;

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        cpustate_q, cpustate_d;
   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   ld_count_q, ld_count_d;
   logic [ADDR_W:0]   chk_ptr_q, chk_ptr_d;
   logic              chk_valid_q, chk_valid_d;
   logic              chk_done_q, chk_done_d;
   logic [DATA_W-1:0] chk_data_q, chk_data_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic in_load, in_check, in_run;
   logic enter_load, enter_check;
   logic ld_full, ld_ready, ld_fire;

   assign in_load     = (state_q == S_LOAD);
   assign in_check    = (state_q == S_CHECK);
   assign in_run      = (state_q == S_RUN);
   assign enter_load  = (state_d == S_LOAD)  && !in_load;
   assign enter_check = (state_d == S_CHECK) && !in_check;

   // The count doubles as the load pointer; its top bit set means every address is written.
   assign ld_full  = ld_count_q[ADDR_W];
   assign ld_ready = in_load && !ld_full;
   assign ld_fire  = ld_ready && bus.ld_valid;

   always_comb begin
      cpustate_d = bus.cpustate;
      state_d    = cpustate_q;
   end

   always_comb begin
      ld_count_d = ld_count_q;
      if (enter_load) begin
         ld_count_d = '0;
      end else if (ld_fire) begin
         ld_count_d = ld_count_q + CNT_ONE;
      end
   end

   // chk_ptr is the next address to fetch, so a new byte is staged in the same
   // cycle the current one is accepted and the stream has no bubble.
   always_comb begin
      chk_ptr_d   = chk_ptr_q;
      chk_valid_d = chk_valid_q;
      chk_done_d  = chk_done_q;
      chk_data_d  = chk_data_q;
      if (enter_check) begin
         chk_ptr_d   = '0;
         chk_valid_d = 1'b0;
         chk_done_d  = 1'b0;
      end else if (in_check) begin
         if (!chk_valid_q || bus.chk_ready) begin
            if (chk_ptr_q < ld_count_q) begin
               chk_data_d  = mem_q[chk_ptr_q[ADDR_W-1:0]];
               chk_valid_d = 1'b1;
               chk_ptr_d   = chk_ptr_q + CNT_ONE;
            end else begin
               chk_valid_d = 1'b0;
               chk_done_d  = 1'b1;
            end
         end
      end
      if (state_d != S_CHECK) begin
         chk_valid_d = 1'b0;
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (in_run && bus.write) begin
         mem_we    = 1'b1;
         mem_waddr = bus.addr;
         mem_wdata = bus.wdata;
      end else if (ld_fire) begin
         mem_we    = 1'b1;
         mem_waddr = ld_count_q[ADDR_W-1:0];
         mem_wdata = bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpustate_q  <= S_IDLE;
         state_q     <= S_IDLE;
         ld_count_q  <= '0;
         chk_ptr_q   <= '0;
         chk_valid_q <= 1'b0;
         chk_done_q  <= 1'b0;
         chk_data_q  <= '0;
      end else begin
         cpustate_q  <= cpustate_d;
         state_q     <= state_d;
         ld_count_q  <= ld_count_d;
         chk_ptr_q   <= chk_ptr_d;
         chk_valid_q <= chk_valid_d;
         chk_done_q  <= chk_done_d;
         chk_data_q  <= chk_data_d;
      end
   end

   // RAM contents survive reset so a loaded program is not lost on a CPU restart.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.rdata     = (in_run && bus.read) ? mem_q[bus.addr] : '0;
   assign bus.ld_ready  = ld_ready;
   assign bus.ld_count  = ld_count_q;
   assign bus.ld_full   = ld_full;
   assign bus.chk_valid = chk_valid_q;
   assign bus.chk_data  = chk_data_q;
   assign bus.chk_done  = chk_done_q;
endmodule
